// File: rtl/me_stage_pkg.sv
// Shared types and helpers for the b-risc memory-access (ME) stage:
// data widths, memory-op and destination-source encodings, and the
// op classification used by the stage and its load aligner.
package me_stage_pkg;

  localparam int WORD_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int REG_IDX_W  = 5;
  localparam int MEM_OP_W   = 4;
  localparam int DEST_SRC_W = 2;

  typedef enum logic [MEM_OP_W-1:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LBU = 4'd4,
    MEM_LHU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_e;

  typedef enum logic [DEST_SRC_W-1:0] {
    DEST_NONE = 2'd0,
    DEST_ALU  = 2'd1,
    DEST_MEM  = 2'd2
  } dest_src_e;

  function automatic logic is_load(input mem_op_e op);
    case (op)
      MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input mem_op_e op);
    case (op)
      MEM_SB, MEM_SH, MEM_SW: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] addr_lo);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return addr_lo[0];
      MEM_LW, MEM_SW:          return |addr_lo;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/me_stage_if.sv
// Data-memory req/ack port of the ME stage. The stage is the master;
// the memory (or its model) is the slave. rdata is valid with ack.
interface me_stage_if
  import me_stage_pkg::*;
();

  logic              o_dmem_req;
  logic              o_dmem_we;
  logic [ADDR_W-1:0] o_dmem_addr;
  logic [3:0]        o_dmem_be;
  logic [WORD_W-1:0] o_dmem_wdata;
  logic              i_dmem_ack;
  logic [WORD_W-1:0] i_dmem_rdata;

  modport master (
    output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
    input  i_dmem_ack, i_dmem_rdata
  );

  modport slave (
    input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
    output i_dmem_ack, i_dmem_rdata
  );

endinterface

// File: rtl/me_stage_load_align.sv
// Load aligner: picks the byte/half lane addressed by addr_lo out of the
// read word and sign- or zero-extends it according to the load op.
module me_load_align
  import me_stage_pkg::*;
(
  input  logic [WORD_W-1:0] rdata,
  input  logic [1:0]        addr_lo,
  input  mem_op_e           mem_op,
  output logic [WORD_W-1:0] word
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select followed by extension of the selected lane.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    word   = rdata;
    case (addr_lo)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
    if (addr_lo[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
    case (mem_op)
      MEM_LB:  word = {{24{byte_s[7]}}, byte_s};
      MEM_LBU: word = {24'h000000, byte_s};
      MEM_LH:  word = {{16{half_s[15]}}, half_s};
      MEM_LHU: word = {16'h0000, half_s};
      MEM_LW:  word = rdata;
      default: word = rdata;
    endcase
  end

endmodule

// File: rtl/me_stage.sv
// b-risc ME stage: latches EX results, runs loads/stores over the dmem
// req/ack port, and drives the ME forwarding bus. o_stall freezes the
// upstream stages while a request is outstanding and unacknowledged.
module me_stage
  import me_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 clr,
  input  logic                 i_stall,
  input  logic [ADDR_W-1:0]    i_pc,
  input  logic [WORD_W-1:0]    i_alu_eval,
  input  logic [WORD_W-1:0]    i_store_data,
  input  mem_op_e              i_mem_op,
  input  dest_src_e            i_dest_src,
  input  logic [REG_IDX_W-1:0] i_dest_reg,
  output logic [ADDR_W-1:0]    o_pc,
  output logic [REG_IDX_W-1:0] o_dest_reg,
  output dest_src_e            o_dest_src,
  output logic [WORD_W-1:0]    o_dest_data,
  output logic                 o_stall,
  output logic                 o_misaligned,
  me_stage_if.master           dmem
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e                state_r, state_nxt_s;
  logic [ADDR_W-1:0]     pc_r;
  logic [WORD_W-1:0]     eval_r, sdata_r, ldata_r;
  mem_op_e               op_r;
  dest_src_e             dsrc_r;
  logic [REG_IDX_W-1:0]  dreg_r;
  logic                  mis_r;

  logic                  busy_s, load_en_s, new_mem_s;
  logic [WORD_W-1:0]     load_src_s, aligned_s;

  assign busy_s    = (state_r == ST_BUSY);
  assign load_en_s = ~o_stall & ~i_stall;
  // A request is started only for an aligned load or store.
  assign new_mem_s = (is_load(i_mem_op) | is_store(i_mem_op)) &
                     ~is_misaligned(i_mem_op, i_alu_eval[1:0]);

  // Pipeline register: bubble on clear, capture EX when nothing freezes us.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pc_r    <= '0;
      eval_r  <= '0;
      sdata_r <= '0;
      op_r    <= MEM_NOP;
      dsrc_r  <= DEST_NONE;
      dreg_r  <= '0;
      mis_r   <= 1'b0;
    end else if (clr) begin
      pc_r    <= '0;
      eval_r  <= '0;
      sdata_r <= '0;
      op_r    <= MEM_NOP;
      dsrc_r  <= DEST_NONE;
      dreg_r  <= '0;
      mis_r   <= 1'b0;
    end else if (load_en_s) begin
      pc_r    <= i_pc;
      eval_r  <= i_alu_eval;
      sdata_r <= i_store_data;
      op_r    <= i_mem_op;
      dsrc_r  <= i_dest_src;
      dreg_r  <= i_dest_reg;
      mis_r   <= is_misaligned(i_mem_op, i_alu_eval[1:0]);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Keep the ack-cycle read word while downstream is frozen.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ldata_r <= '0;
    end else if (busy_s && dmem.i_dmem_ack && i_stall && !clr) begin
      ldata_r <= dmem.i_dmem_rdata;
    end
  end

  // Next state: clear first, then a pipeline load, then the ack-under-stall park.
  always_comb begin
    state_nxt_s = state_r;
    if (clr) begin
      state_nxt_s = ST_IDLE;
    end else if (load_en_s) begin
      state_nxt_s = new_mem_s ? ST_BUSY : ST_IDLE;
    end else if (busy_s && dmem.i_dmem_ack) begin
      state_nxt_s = ST_HOLD;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Request side: byte enables and lane-replicated store data.
  always_comb begin
    dmem.o_dmem_be    = 4'b0000;
    dmem.o_dmem_wdata = sdata_r;
    case (op_r)
      MEM_SB: begin
        dmem.o_dmem_be    = 4'b0001 << eval_r[1:0];
        dmem.o_dmem_wdata = {4{sdata_r[7:0]}};
      end
      MEM_SH: begin
        dmem.o_dmem_be    = eval_r[1] ? 4'b1100 : 4'b0011;
        dmem.o_dmem_wdata = {2{sdata_r[15:0]}};
      end
      MEM_SW, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: begin
        dmem.o_dmem_be    = 4'b1111;
        dmem.o_dmem_wdata = sdata_r;
      end
      default: begin
        dmem.o_dmem_be    = 4'b0000;
        dmem.o_dmem_wdata = sdata_r;
      end
    endcase
    if (!busy_s) begin
      dmem.o_dmem_be = 4'b0000;
    end else begin
      dmem.o_dmem_be = dmem.o_dmem_be;
    end
  end

  assign dmem.o_dmem_req  = busy_s;
  assign dmem.o_dmem_we   = busy_s & is_store(op_r);
  assign dmem.o_dmem_addr = {eval_r[ADDR_W-1:2], 2'b00};
  assign o_stall          = busy_s & ~dmem.i_dmem_ack;

  // In HOLD the bus may carry anything, so the latched word is used instead.
  assign load_src_s = (state_r == ST_HOLD) ? ldata_r : dmem.i_dmem_rdata;

  me_load_align u_load_align (
    .rdata   (load_src_s),
    .addr_lo (eval_r[1:0]),
    .mem_op  (op_r),
    .word    (aligned_s)
  );

  assign o_pc         = pc_r;
  assign o_dest_reg   = dreg_r;
  assign o_misaligned = mis_r;
  assign o_dest_data  = is_load(op_r) ? aligned_s : eval_r;
  assign o_dest_src   = (mis_r | is_store(op_r)) ? DEST_NONE : dsrc_r;

endmodule
